// File: rtl/mux_pkg.sv
// Shared types for the pipelined N:1 selector.
// Entry layout and state encoding for the two-entry skid buffer.
`define SEL_ENTRY_T(W, S) struct packed { \
    logic [(W)-1:0] data; \
    logic [(S)-1:0] src; \
    logic           err; \
}

package mux_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_N_INPUTS = 4;

    typedef `SEL_ENTRY_T(DEF_WIDTH, $clog2(DEF_N_INPUTS)) sel_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N:1 word select with out-of-range detection.
// Out-of-range selects produce an all-zero word and err=1.
module mux_nx1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int N_INPUTS = DEF_N_INPUTS,
    localparam int SEL_W   = $clog2(N_INPUTS)
) (
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          word,
    output logic                      err
);

    logic [31:0] sel_ext;

    assign sel_ext = {{(32-SEL_W){1'b0}}, sel};
    assign err     = (sel_ext >= 32'(N_INPUTS));

    always_comb begin
        word = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (sel == SEL_W'(k)) begin
                word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 selector with a registered two-entry skid buffer output.
// in_ready depends only on registered state, never on out_ready.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int N_INPUTS = DEF_N_INPUTS,
    localparam int SEL_W   = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_src,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef `SEL_ENTRY_T(WIDTH, SEL_W) entry_t;

    state_t           state;
    entry_t           head;
    entry_t           tail;
    entry_t           nxt;
    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic             push;
    logic             pop;

    mux_nx1_comb #(
        .WIDTH    (WIDTH),
        .N_INPUTS (N_INPUTS)
    ) u_comb (
        .in_data (in_data),
        .sel     (in_sel),
        .word    (sel_word),
        .err     (sel_err)
    );

    assign nxt.data = sel_word;
    assign nxt.src  = in_sel;
    assign nxt.err  = sel_err;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = head.data;
    assign out_src   = head.src;
    assign out_err   = head.err;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= nxt;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= nxt;
                    end else if (push) begin
                        tail  <= nxt;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // Full: only a pop can move, promoting the tail.
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
